// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronises and glitch-filters the A/B pins,
// decodes Gray-code transitions into STEP/INC, and flags double-bit jumps on ERR.
// Optional index channel (IDX -> LOAD) is built only when QDEC_INDEX_EN is defined.
//
// state | meaning
// ------+---------------------------------------------
// S00   | last accepted filtered pair {A,B} = 00
// S10   | last accepted filtered pair {A,B} = 10
// S11   | last accepted filtered pair {A,B} = 11
// S01   | last accepted filtered pair {A,B} = 01
module quad_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int ERR_W       = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             A,
  input  logic             B,
  input  logic             CLR_ERR,
`ifdef QDEC_INDEX_EN
  input  logic             IDX,
`endif
  output logic             STEP,
  output logic             INC,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             LOAD
);

`ifdef QDEC_INDEX_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif
  localparam logic [3:0] FL_M1 = 4'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S10 = 2'b10,
    S11 = 2'b11,
    S01 = 2'b01
  } state_t;

  logic [NCH-1:0]                  pins;
  logic [NCH-1:0][SYNC_STAGES-1:0] sync_q;
  logic [NCH-1:0]                  sync_out;
  logic [NCH-1:0]                  filt_q;
  logic [NCH-1:0][3:0]             cnt_q;

  state_t state_q, state_nxt;
  logic   step_nxt, inc_nxt, err_nxt;

`ifdef QDEC_INDEX_EN
  assign pins = {IDX, B, A};
`else
  assign pins = {B, A};
`endif

  // Synchroniser shift chain per pin; the last stage feeds the filter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pins[i]};
      end
    end
  end

  always_comb begin
    sync_out = '0;
    for (int i = 0; i < NCH; i++) begin
      sync_out[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Persistence filter: a new level is accepted once it has been seen FILTER_LEN edges in a row.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      filt_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync_out[i] != filt_q[i]) begin
          if (cnt_q[i] == FL_M1) begin
            filt_q[i] <= sync_out[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 4'd1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Gray decode: compare the last accepted pair with the current filtered pair.
  always_comb begin
    state_t ab;
    ab        = state_t'({filt_q[0], filt_q[1]});
    state_nxt = ab;
    step_nxt  = 1'b0;
    inc_nxt   = INC;
    err_nxt   = 1'b0;
    if (ab != state_q) begin
      if (ab == state_t'(~state_q)) begin
        err_nxt = 1'b1;
      end else begin
        step_nxt = 1'b1;
        unique case (state_q)
          S00:     inc_nxt = (ab == S10);
          S10:     inc_nxt = (ab == S11);
          S11:     inc_nxt = (ab == S01);
          default: inc_nxt = (ab == S00);
        endcase
      end
    end
  end

  // State register and registered decode outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S00;
      STEP    <= 1'b0;
      INC     <= 1'b1;
      ERR     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      STEP    <= step_nxt;
      INC     <= inc_nxt;
      ERR     <= err_nxt;
    end
  end

  // Saturating count of ERR pulses; a clear wins over the pulse it coincides with.
  always_ff @(posedge CLK) begin
    if (RESET || CLR_ERR) begin
      ERR_CNT <= '0;
    end else if (ERR && (ERR_CNT != '1)) begin
      ERR_CNT <= ERR_CNT + 1'b1;
    end
  end

`ifdef QDEC_INDEX_EN
  logic idx_prev_q;

  // Index rising edge on the filtered level, aligned with the STEP pipeline.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx_prev_q <= 1'b0;
      LOAD       <= 1'b0;
    end else begin
      idx_prev_q <= filt_q[2];
      LOAD       <= filt_q[2] & ~idx_prev_q;
    end
  end
`else
  assign LOAD = 1'b0;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: vector table for the A/B sequences plus
// hand-written sequences for latency, glitch rejection, clear priority and reset.
module tb_quad_decoder;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic       CLR_ERR = 1'b0;
  logic       IDX = 1'b0;
  logic       STEP, INC, ERR, LOAD;
  logic [7:0] ERR_CNT;
  logic       step2, inc2, err2, load2;
  logic [1:0] err_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  quad_decoder dut (
    .CLK(CLK), .RESET(RESET), .A(A), .B(B), .CLR_ERR(CLR_ERR),
`ifdef QDEC_INDEX_EN
    .IDX(IDX),
`endif
    .STEP(STEP), .INC(INC), .ERR(ERR), .ERR_CNT(ERR_CNT), .LOAD(LOAD)
  );

  quad_decoder #(.ERR_W(2)) dut_w2 (
    .CLK(CLK), .RESET(RESET), .A(A), .B(B), .CLR_ERR(CLR_ERR),
`ifdef QDEC_INDEX_EN
    .IDX(IDX),
`endif
    .STEP(step2), .INC(inc2), .ERR(err2), .ERR_CNT(err_cnt2), .LOAD(load2)
  );

  typedef struct {
    logic a;
    logic b;
    int   hold;
    int   steps;
    logic inc;
    int   errs;
    int   cnt;
  } vec_t;

  vec_t vecs[16];

  int steps, errs, loads, first_step, first_load, first_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock edge, then sample 1 time unit later; tallies pulses and first-seen tick.
  task automatic tick(input int t);
    @(posedge CLK);
    #1;
    if (STEP) begin steps++; if (first_step == 0) first_step = t; end
    if (ERR)  begin errs++;  if (first_err == 0)  first_err = t;  end
    if (LOAD) begin loads++; if (first_load == 0) first_load = t; end
  endtask

  task automatic clear_tally();
    steps = 0; errs = 0; loads = 0; first_step = 0; first_err = 0; first_load = 0;
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      A = vecs[i].a;
      B = vecs[i].b;
      clear_tally();
      for (int t = 1; t <= vecs[i].hold; t++) tick(t);
      check($sformatf("row%0d_steps", i), steps, vecs[i].steps);
      check($sformatf("row%0d_errs", i), errs, vecs[i].errs);
      check($sformatf("row%0d_inc", i), INC, vecs[i].inc);
      check($sformatf("row%0d_errcnt", i), ERR_CNT, vecs[i].cnt);
      check($sformatf("row%0d_errcnt_w2", i), err_cnt2, (vecs[i].cnt > 3) ? 3 : vecs[i].cnt);
      check($sformatf("row%0d_loads", i), loads, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_loads;
    //          a     b     hold steps inc   errs cnt
    vecs[0]  = '{1'b1, 1'b1, 10, 1, 1'b1, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 10, 1, 1'b1, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 10, 1, 1'b1, 0, 0};
    vecs[3]  = '{1'b0, 1'b1, 10, 1, 1'b0, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, 10, 1, 1'b1, 0, 0};
    vecs[5]  = '{1'b0, 1'b1, 10, 1, 1'b0, 0, 0};
    vecs[6]  = '{1'b1, 1'b1, 10, 1, 1'b0, 0, 0};
    vecs[7]  = '{1'b1, 1'b0, 10, 1, 1'b0, 0, 0};
    vecs[8]  = '{1'b0, 1'b0, 10, 1, 1'b0, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 10, 0, 1'b0, 1, 1};
    vecs[10] = '{1'b0, 1'b0, 10, 0, 1'b0, 1, 2};
    vecs[11] = '{1'b1, 1'b1, 10, 0, 1'b0, 1, 3};
    vecs[12] = '{1'b0, 1'b0, 10, 0, 1'b0, 1, 4};
    vecs[13] = '{1'b1, 1'b1, 10, 0, 1'b0, 1, 5};
    vecs[14] = '{1'b0, 1'b0, 10, 0, 1'b0, 1, 6};
    vecs[15] = '{1'b0, 1'b0, 10, 0, 1'b0, 1, 1};

`ifdef QDEC_INDEX_EN
    exp_loads = 1;
`else
    exp_loads = 0;
`endif

    // Reset values.
    clear_tally();
    for (int t = 1; t <= 3; t++) tick(t);
    check("rst_step", STEP, 0);
    check("rst_inc", INC, 1);
    check("rst_err", ERR, 0);
    check("rst_errcnt", ERR_CNT, 0);
    check("rst_load", LOAD, 0);
    RESET = 1'b0;
    for (int t = 1; t <= 2; t++) tick(t);

    // First up step: latency 6 edges from the edge that samples A high.
    A = 1'b1;
    IDX = 1'b1;
    clear_tally();
    for (int t = 1; t <= 10; t++) tick(t);
    check("first_step_tick", first_step, 6);
    check("first_steps", steps, 1);
    check("first_inc", INC, 1);
    check("first_errs", errs, 0);
    check("first_loads", loads, exp_loads);
    check("first_load_tick", first_load, exp_loads * 6);

    run_rows(0, 2);

    // 2-cycle glitch on A is filtered out; state remains S00.
    A = 1'b1;
    clear_tally();
    tick(1);
    tick(2);
    A = 1'b0;
    for (int t = 3; t <= 12; t++) tick(t);
    check("glitch_steps", steps, 0);
    check("glitch_errs", errs, 0);

    // 00->01 must decode as a down step (state S00), then the reverse sequence.
    run_rows(3, 8);

    // Illegal double-bit transitions, ERR_CNT counting and 2-bit saturation.
    run_rows(9, 14);

    // Clear issued in the same cycle as the 7th ERR pulse.
    A = 1'b1;
    B = 1'b1;
    clear_tally();
    for (int t = 1; t <= 6; t++) tick(t);
    check("clr_err_tick", first_err, 6);
    CLR_ERR = 1'b1;
    tick(7);
    CLR_ERR = 1'b0;
    for (int t = 8; t <= 12; t++) tick(t);
    check("clr_errcnt", ERR_CNT, 0);
    check("clr_errcnt_w2", err_cnt2, 0);
    check("clr_errs", errs, 1);

    run_rows(15, 15);

    // Reset in the middle of an in-flight transition.
    A = 1'b1;
    clear_tally();
    for (int t = 1; t <= 3; t++) tick(t);
    RESET = 1'b1;
    B = 1'b1;
    tick(4);
    check("midrst_step", STEP, 0);
    check("midrst_inc", INC, 1);
    check("midrst_err", ERR, 0);
    check("midrst_errcnt", ERR_CNT, 0);
    check("midrst_load", LOAD, 0);
    tick(5);
    RESET = 1'b0;

    // A=B=1 at reset release is decoded from S00 as an illegal transition.
    clear_tally();
    for (int t = 1; t <= 10; t++) tick(t);
    check("rel_err_tick", first_err, 6);
    check("rel_errs", errs, 1);
    check("rel_steps", steps, 0);
    check("rel_errcnt", ERR_CNT, 1);
    check("rel_inc", INC, 1);
    check("rel_loads", loads, exp_loads);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
